somasub_serial: RTL
===================

# somasub_serial

Nibble-serial controller that sequences a 4-bit add/subtract slice to perform WORDS×4-bit two's-complement addition and subtraction. It latches full-width operands on a start handshake, steps one nibble per clock from LSB to MSB while chaining the carry, then publishes the result and the zero/sign/overflow/carry flags with a one-cycle done pulse. It sits between wide-operand requesters and the 4-bit somasub datapath, so wide arithmetic reuses the narrow slice instead of a full-width adder.

## Interface
- WORDS, default 4: number of nibbles per operand; width N = 4*WORDS; legal range WORDS ≥ 2.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when not busy.
- op  in  1  0 = A + B, 1 = A − B; sampled with start.
- A  in  N  operand A; sampled with start.
- B  in  N  operand B; sampled with start.
- busy  out  1  high while a nibble sequence is running.
- done  out  1  one-cycle pulse; R and flags valid from this cycle on.
- R  out  N  result; registered and held until the next completion.
- zero  out  1  R == 0.
- sinal  out  1  R[N−1].
- overflow  out  1  signed overflow of the N-bit operation.
- carry  out  1  carry out of bit N−1; for subtraction, 1 = no borrow (A ≥ B unsigned).

## Operation
- FSM states: IDLE, RUN. Nibble counter cnt, width clog2(WORDS).
- IDLE with start=1: latch a_q=A, b_q=(op ? ~B : B), op_q=op, c=op, cnt=0, zero accumulator=1. Go to RUN. busy=1 from the next cycle.
- RUN, each cycle: s = a_q[4cnt+3:4cnt] + b_q[4cnt+3:4cnt] + c, 5-bit result.
  - Write s[3:0] into working register W at nibble cnt.
  - c ← s[4].
  - zero accumulator &= (s[3:0] == 0).
  - cnt ← cnt+1.
- RUN with cnt == WORDS−1, same cycle:
  - R ← W with the final nibble merged.
  - sinal ← s[3].
  - carry ← s[4].
  - zero ← accumulator including the final nibble.
  - overflow ← (carry into bit N−1) XOR s[4]. Equivalently, with effective operand b_q: (~a_msb & ~b_msb & r_msb) | (a_msb & b_msb & ~r_msb).
  - done ← 1, busy ← 0, state ← IDLE.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle is accepted, because the state is already IDLE. This gives back-to-back operation with no dead cycle.
- Outputs R, zero, sinal, overflow and carry change only at completion. They never show partial results during RUN.
- op, A and B may change freely after the sampling edge; only the latched copies are used.

## Timing
- Sampling edge E0 (start=1, IDLE). RUN occupies edges E1..E(WORDS). done, R and flags update at edge E(WORDS).
- Latency: start-to-done = WORDS cycles. Throughput: one operation per WORDS cycles.
- busy high for exactly WORDS cycles per operation. done high for exactly 1 cycle.
- Reset values (rst_n=0 at any edge): state IDLE, cnt 0, busy 0, done 0, R 0, zero 1, sinal 0, overflow 0, carry 0.
- Reset mid-RUN: the operation is aborted, no done is issued, and all outputs take reset values at that edge.
- Reset has priority over start in the same cycle.

## Test plan
- Add, WORDS=4: A=0x1234, B=0x0FCD, op=0 -> busy for 4 cycles, done at E4, R=0x2201, zero 0, sinal 0, overflow 0, carry 0.
- Subtract with a negative operand: A=0x0004, B=0xFFFB, op=1 -> R=0x0009, overflow 0, sinal 0, carry 0 (borrow).
- Overflow, two operations:
  - 0x7FFF+0x0001 -> R=0x8000, overflow 1, sinal 1, carry 0.
  - 0x8000−0x0001 -> R=0x7FFF, overflow 1, sinal 0, carry 1.
- Zero and wrap, two operations:
  - 0x1234−0x1234 -> R=0, zero 1, carry 1, overflow 0.
  - 0xFFFF+0x0001 -> R=0, zero 1, carry 1, overflow 0.
- Handshake:
  - Hold start=1 with changing A during busy -> those requests are ignored, and R holds the previous result until done.
  - Assert start in the done cycle -> the second operation completes exactly 4 cycles later.
- Reset: drop rst_n after 2 RUN cycles -> no done, all outputs at reset values (zero=1). A subsequent start of 0x0001+0x0001 -> R=0x0002.

Source files
------------

// File: rtl/somasub_serial.sv
// somasub_serial: WORDS x 4-bit two's-complement add/subtract sequenced over one 4-bit slice.
// Latency: start-to-done = WORDS cycles; throughput one operation per WORDS cycles.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.

// somasub_nibble: 4-bit add slice with carry in/out and per-slice signed overflow.
// Latency: combinational.
// Backpressure: not applicable.
module somasub_nibble (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c,
    output logic       o_v
);
    logic [4:0] w_sum;
    logic       w_c_into_msb;

    assign w_sum        = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_c};
    assign o_s          = w_sum[3:0];
    assign o_c          = w_sum[4];
    // Carry into bit 3 recovered from the sum bit; overflow is carry-in vs carry-out of the MSB.
    assign w_c_into_msb = i_a[3] ^ i_b[3] ^ w_sum[3];
    assign o_v          = w_c_into_msb ^ w_sum[4];
endmodule

module somasub_serial #(
    parameter int WORDS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_op,
    input  logic [4*WORDS-1:0]   i_a,
    input  logic [4*WORDS-1:0]   i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*WORDS-1:0]   o_r,
    output logic                 o_zero,
    output logic                 o_sinal,
    output logic                 o_overflow,
    output logic                 o_carry
);
    localparam int N  = 4 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW = CW + 2;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;      // already inverted for subtraction
    logic            r_c;
    logic            r_zacc;
    logic [N-1:0]    r_w;

    logic [N-1:0]    r_r;
    logic            r_done;
    logic            r_zero;
    logic            r_sinal;
    logic            r_ovf;
    logic            r_carry;

    logic            w_busy;
    logic            w_load;
    logic            w_step;
    logic            w_finish;
    logic [IW-1:0]   w_base;
    logic [3:0]      w_nib_a;
    logic [3:0]      w_nib_b;
    logic [3:0]      w_nib_s;
    logic            w_nib_c;
    logic            w_nib_v;
    logic            w_nib_zero;
    logic [N-1:0]    w_w_fin;

    // State register; reset aborts any running sequence.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave IDLE on start, return after the last nibble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start)        w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST)  w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    // FSM decode: load on accepted start, step every RUN cycle, finish on the last nibble.
    always_comb begin
        w_busy   = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = i_start;
            end
            S_RUN: begin
                w_busy   = 1'b1;
                w_step   = 1'b1;
                w_finish = (r_cnt == LAST);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Select the active nibble of each latched operand.
    assign w_base  = {r_cnt, 2'b00};
    assign w_nib_a = r_a[w_base +: 4];
    assign w_nib_b = r_b[w_base +: 4];

    somasub_nibble u_slice (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .i_c (r_c),
        .o_s (w_nib_s),
        .o_c (w_nib_c),
        .o_v (w_nib_v)
    );

    assign w_nib_zero = (w_nib_s == 4'h0);

    // Working register with the final nibble merged, so R is published in the same cycle.
    always_comb begin
        w_w_fin = r_w;
        w_w_fin[w_base +: 4] = w_nib_s;
    end

    // Operand latch and per-nibble stepping of carry, counter, zero accumulator and W.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_zacc <= 1'b1;
            r_w    <= '0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_a    <= i_a;
            r_b    <= i_op ? ~i_b : i_b;
            r_c    <= i_op;
            r_zacc <= 1'b1;
        end else if (w_step) begin
            r_w[w_base +: 4] <= w_nib_s;
            r_c    <= w_nib_c;
            r_zacc <= r_zacc & w_nib_zero;
            r_cnt  <= w_finish ? '0 : r_cnt + CW'(1);
        end
    end

    // Publish result and flags only on completion; done is a single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_done  <= 1'b0;
            r_r     <= '0;
            r_zero  <= 1'b1;
            r_sinal <= 1'b0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_r     <= w_w_fin;
                r_zero  <= r_zacc & w_nib_zero;
                r_sinal <= w_nib_s[3];
                r_ovf   <= w_nib_v;
                r_carry <= w_nib_c;
            end
        end
    end

    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_r        = r_r;
    assign o_zero     = r_zero;
    assign o_sinal    = r_sinal;
    assign o_overflow = r_ovf;
    assign o_carry    = r_carry;
endmodule
